// File: rtl/mdu_pkg.sv
//------------------------------------------------------------------------------
// Module : mdu_pkg
// Brief  : Funct codes, FSM state type and decode helpers for the MIPS HI/LO unit
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // True for the funct codes that launch a multi-cycle operation.
  function automatic logic is_mdu_start(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
//------------------------------------------------------------------------------
// Module : mdu_step
// Brief  : One combinational shift-add (multiply) or restore-subtract (divide) step
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_opd,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shl_hi;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, consumed LSB first.
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opd} : '0);
    // Divide: acc = {partial remainder, remaining dividend / growing quotient}.
    w_shl_hi = i_acc[2*WIDTH-1:WIDTH-1];
    w_ge     = (w_shl_hi >= {1'b0, i_opd});
    w_diff   = w_shl_hi - {1'b0, i_opd};
    if (i_is_div) begin
      if (w_ge) begin
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_shl_hi[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
//------------------------------------------------------------------------------
// Module : mul_div_unit
// Brief  : Iterative MIPS mult/div unit with HI/LO registers and busy/done handshake
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [5:0]       i_funct,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_dz;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_idle_req;
  logic                 w_accept;
  logic                 w_signed;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;
  logic [2*WIDTH-1:0]   w_chain [BITS_PER_CYCLE+1];

  assign w_idle_req = (r_state == IDLE) && i_start && !i_flush;
  assign w_accept   = w_idle_req && is_mdu_start(i_funct);
  assign w_signed   = is_signed_op(i_funct);
  assign w_abs_a    = (w_signed && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
  assign w_abs_b    = (w_signed && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;

  assign w_chain[0] = r_acc;
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    mdu_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (w_chain[gi]),
      .i_opd    (r_opd),
      .o_acc    (w_chain[gi+1])
    );
  end

  // Sign correction on the magnitude result; divide-by-zero forces an all-ones quotient
  // while the remainder path already reproduces the original dividend.
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? (r_dz ? '1 : (r_neg_q ? -w_quo : w_quo)) : w_prod[WIDTH-1:0];
  assign w_fix_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (i_flush) w_next = IDLE;
               else if (r_cnt == CNT_W'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_div <= is_div_op(i_funct);
            r_neg_q  <= w_signed && (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
            r_neg_r  <= w_signed && i_op_a[WIDTH-1];
            r_dz     <= (i_op_b == '0);
            r_cnt    <= CNT_W'(ITERS);
            if (is_div_op(i_funct)) begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_a};
              r_opd <= w_abs_b;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_b};
              r_opd <= w_abs_a;
            end
          end else if (w_idle_req && (i_funct == FUNCT_MTHI)) begin
            r_hi <= i_op_a;
          end else if (w_idle_req && (i_funct == FUNCT_MTLO)) begin
            r_lo <= i_op_a;
          end
        end
        CALC: begin
          if (i_flush) begin
            r_cnt <= '0;
          end else begin
            r_acc <= w_chain[BITS_PER_CYCLE];
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          r_cnt <= '0;
          if (!i_flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

`default_nettype wire
